// File: rtl/matrix_uart_printer_pkg.sv
// Shared definitions for the matrix UART printer.
//   ASCII_*  : character constants used when building output fields
//   state_t  : printer FSM states
//   clog2    : ceil(log2(v)) helper for parameter-derived widths
package matrix_uart_printer_pkg;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CONV,
        ST_EMIT,
        ST_SEND,
        ST_GAP,
        ST_WAIT,
        ST_NEXT,
        ST_FIN,
        ST_ERR
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/matrix_uart_printer_if.sv
// Byte stream link between the matrix printer and the UART transmitter.
//   tx_start : one-cycle byte strobe (printer -> uart)
//   tx_data  : byte, valid while tx_start is high (printer -> uart)
//   tx_busy  : transmitter busy (uart -> printer)
interface matrix_uart_printer_if;

    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (output tx_start, output tx_data, input tx_busy);
    modport slave  (input tx_start, input tx_data, output tx_busy);

endinterface

// File: rtl/matrix_uart_printer_bin2dec_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, double dabble).
//   clk, rst : clock, asynchronous active-high reset
//   start    : one-cycle pulse, loads din and begins conversion
//   din      : unsigned binary input, IN_W bits
//   done     : one-cycle pulse IN_W cycles after start; bcd/lead valid then
//   bcd      : packed BCD digits, digit 0 in bcd[3:0] (least significant)
//   lead     : index of the most significant non-zero digit (0 for value 0)
module matrix_uart_printer_bin2dec_seq
    import matrix_uart_printer_pkg::*;
#(
    parameter int unsigned IN_W   = 10,
    parameter int unsigned DIGITS = 3,
    localparam int unsigned LW    = (DIGITS > 1) ? clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       din,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd,
    output logic [LW-1:0]         lead
);

    localparam int unsigned CNT_W = clog2(IN_W + 1);

    logic [IN_W-1:0]     sh;
    logic [DIGITS*4-1:0] work;
    logic [DIGITS*4-1:0] adj;
    logic [CNT_W-1:0]    cnt;
    logic                running;

    // Any digit >= 5 is corrected by +3 so the following shift carries properly.
    always_comb begin
        adj = work;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (work[d*4 +: 4] >= 4'd5) begin
                adj[d*4 +: 4] = work[d*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        lead = '0;
        for (int unsigned d = 1; d < DIGITS; d++) begin
            if (work[d*4 +: 4] != 4'd0) begin
                lead = LW'(d);
            end
        end
    end

    assign bcd = work;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh      <= '0;
            work    <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sh      <= din;
                work    <= '0;
                cnt     <= CNT_W'(IN_W);
                running <= 1'b1;
            end else if (running) begin
                {work, sh} <= {adj, sh} << 1;
                cnt        <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/matrix_uart_printer.sv
// Streams a row-major matrix to a UART transmitter as fixed-width,
// left-justified ASCII decimal fields; each row ends in LF.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : rising edge accepted in IDLE only
//   abort      : stop after the byte currently on the wire
//   rows, cols : runtime dimensions (1..MAX_ROWS, 1..MAX_COLS)
//   data_flat  : element k = r*cols+c at [k*DATA_W +: DATA_W]
//   busy       : high from accepted start until done/err/abort
//   done       : one-cycle pulse, whole matrix sent
//   err        : one-cycle pulse, bad dimensions, nothing sent
//   tx         : byte link to the transmitter (tx_start/tx_data/tx_busy)
module matrix_uart_printer
    import matrix_uart_printer_pkg::*;
#(
    parameter int unsigned DATA_W    = 9,
    parameter int unsigned MAX_ROWS  = 5,
    parameter int unsigned MAX_COLS  = 5,
    parameter int unsigned DIGITS    = 3,
    parameter int unsigned SIGNED_EN = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                abort,
    input  logic [clog2(MAX_ROWS+1)-1:0]        rows,
    input  logic [clog2(MAX_COLS+1)-1:0]        cols,
    input  logic [MAX_ROWS*MAX_COLS*DATA_W-1:0] data_flat,
    output logic                                busy,
    output logic                                done,
    output logic                                err,
    matrix_uart_printer_if.master               tx
);

    localparam int unsigned RW = clog2(MAX_ROWS + 1);
    localparam int unsigned CW = clog2(MAX_COLS + 1);
    localparam int unsigned NE = MAX_ROWS * MAX_COLS;
    localparam int unsigned IW = clog2(NE) + 1;
    localparam int unsigned MW = DATA_W + 1;
    localparam int unsigned FW = DIGITS + SIGNED_EN;
    localparam int unsigned PW = clog2(FW + 1);
    localparam int unsigned LW = (DIGITS > 1) ? clog2(DIGITS) : 1;

    state_t                 state;
    logic                   start_d;
    logic                   abort_l;
    logic [RW-1:0]          rows_s;
    logic [CW-1:0]          cols_s;
    logic [RW-1:0]          r;
    logic [CW-1:0]          c;
    logic [NE*DATA_W-1:0]   snap;
    logic [IW-1:0]          idx;
    logic [DATA_W-1:0]      elem;
    logic                   neg_c;
    logic                   neg_l;
    logic [MW-1:0]          sext;
    logic [MW-1:0]          mag;
    logic [MW-1:0]          conv_din;
    logic                   conv_start;
    logic                   conv_done;
    logic [DIGITS*4-1:0]    conv_bcd;
    logic [LW-1:0]          conv_lead;
    logic [DIGITS*4-1:0]    bcd_l;
    logic [LW-1:0]          lead_l;
    logic [PW-1:0]          ch;
    logic [7:0]             char_c;
    logic [31:0]            pre;
    logic [31:0]            nd;
    logic [31:0]            q;
    logic                   last_col;
    logic                   last_row;
    logic                   accept;
    logic                   dims_bad;
    logic                   tx_start_r;
    logic [7:0]             tx_data_r;

    assign tx.tx_start = tx_start_r;
    assign tx.tx_data  = tx_data_r;

    assign accept   = start & ~start_d & (state == ST_IDLE);
    assign dims_bad = (rows == '0) || (cols == '0) ||
                      (rows > RW'(MAX_ROWS)) || (cols > CW'(MAX_COLS));

    assign idx      = IW'(r) * IW'(cols_s) + IW'(c);
    assign last_col = (c == cols_s - CW'(1));
    assign last_row = (r == rows_s - RW'(1));

    always_comb begin
        elem = '0;
        for (int unsigned k = 0; k < NE; k++) begin
            if (idx == IW'(k)) begin
                elem = snap[k*DATA_W +: DATA_W];
            end
        end
    end

    // One extra bit so the most negative value negates without overflow.
    assign neg_c = (SIGNED_EN != 0) && elem[DATA_W-1];
    assign sext  = {neg_c, elem};
    assign mag   = neg_c ? (~sext + MW'(1)) : sext;

    // Field character at position ch: optional '-', significant digits
    // most-significant first, space padding; position FW is the separator.
    always_comb begin
        pre    = {31'd0, neg_l};
        nd     = 32'(lead_l) + 32'd1;
        q      = '0;
        char_c = ASCII_SPACE;
        if (ch == PW'(FW)) begin
            char_c = last_col ? ASCII_LF : ASCII_SPACE;
        end else if (32'(ch) < pre) begin
            char_c = ASCII_MINUS;
        end else begin
            q = 32'(ch) - pre;
            for (int unsigned d = 0; d < DIGITS; d++) begin
                if ((q < nd) && (d == nd - 32'd1 - q)) begin
                    char_c = ASCII_0 + {4'h0, bcd_l[d*4 +: 4]};
                end
            end
        end
    end

    matrix_uart_printer_bin2dec_seq #(
        .IN_W   (MW),
        .DIGITS (DIGITS)
    ) u_bin2dec (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .din   (conv_din),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .lead  (conv_lead)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            start_d    <= 1'b0;
            abort_l    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            tx_start_r <= 1'b0;
            tx_data_r  <= '0;
            rows_s     <= '0;
            cols_s     <= '0;
            r          <= '0;
            c          <= '0;
            snap       <= '0;
            neg_l      <= 1'b0;
            conv_din   <= '0;
            conv_start <= 1'b0;
            bcd_l      <= '0;
            lead_l     <= '0;
            ch         <= '0;
        end else begin
            start_d    <= start;
            done       <= 1'b0;
            err        <= 1'b0;
            tx_start_r <= 1'b0;
            conv_start <= 1'b0;
            if ((state != ST_IDLE) && abort) begin
                abort_l <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        rows_s  <= rows;
                        cols_s  <= cols;
                        snap    <= data_flat;
                        r       <= '0;
                        c       <= '0;
                        abort_l <= 1'b0;
                        busy    <= 1'b1;
                        state   <= dims_bad ? ST_ERR : ST_LOAD;
                    end
                end
                ST_ERR: begin
                    err   <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                ST_LOAD: begin
                    conv_din   <= mag;
                    neg_l      <= neg_c;
                    conv_start <= 1'b1;
                    state      <= ST_CONV;
                end
                ST_CONV: begin
                    if (conv_done) begin
                        bcd_l  <= conv_bcd;
                        lead_l <= conv_lead;
                        ch     <= '0;
                        state  <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    tx_data_r <= char_c;
                    state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (!tx.tx_busy) begin
                        tx_start_r <= 1'b1;
                        state      <= ST_GAP;
                    end
                end
                // The transmitter may raise tx_busy a cycle late; skip one cycle.
                ST_GAP: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!tx.tx_busy) begin
                        if (abort_l) begin
                            abort_l <= 1'b0;
                            busy    <= 1'b0;
                            state   <= ST_IDLE;
                        end else if (ch == PW'(FW)) begin
                            state <= ST_NEXT;
                        end else begin
                            ch    <= ch + PW'(1);
                            state <= ST_EMIT;
                        end
                    end
                end
                ST_NEXT: begin
                    if (last_col && last_row) begin
                        state <= ST_FIN;
                    end else begin
                        if (last_col) begin
                            c <= '0;
                            r <= r + RW'(1);
                        end else begin
                            c <= c + CW'(1);
                        end
                        state <= ST_LOAD;
                    end
                end
                ST_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_uart_printer.sv
// Bench for matrix_uart_printer: one unsigned and one signed instance,
// a transmitter busy model per instance, and a text-level reference model.
module tb_matrix_uart_printer;

    localparam int DW = 9;
    localparam int MR = 5;
    localparam int MC = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_u = 1'b0;
    logic start_s = 1'b0;
    logic abort_i = 1'b0;
    logic [2:0] rows_i = 3'd0;
    logic [2:0] cols_i = 3'd0;
    logic [MR*MC*DW-1:0] data_flat = '0;
    logic busy_u, done_u, err_u;
    logic busy_s, done_s, err_s;

    matrix_uart_printer_if if_u ();
    matrix_uart_printer_if if_s ();

    matrix_uart_printer #(
        .DATA_W(DW), .MAX_ROWS(MR), .MAX_COLS(MC), .DIGITS(3), .SIGNED_EN(0)
    ) dut_u (
        .clk(clk), .rst(rst), .start(start_u), .abort(abort_i),
        .rows(rows_i), .cols(cols_i), .data_flat(data_flat),
        .busy(busy_u), .done(done_u), .err(err_u), .tx(if_u)
    );

    matrix_uart_printer #(
        .DATA_W(DW), .MAX_ROWS(MR), .MAX_COLS(MC), .DIGITS(3), .SIGNED_EN(1)
    ) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .abort(abort_i),
        .rows(rows_i), .cols(cols_i), .data_flat(data_flat),
        .busy(busy_s), .done(done_s), .err(err_s), .tx(if_s)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    failures = 0;
    string exp_str [2];
    string rx [2];
    int    pos [2];
    int    tx_cnt [2];
    int    done_cnt [2];
    int    err_cnt [2];
    int    busy_cd [2];
    bit    rand_lag [2];
    logic  prev_st [2];
    int    vals [25];

    logic       m_st [2];
    logic [7:0] m_td [2];
    logic       m_bz [2];
    logic       m_dn [2];
    logic       m_er [2];
    string      m_es;

    function automatic void check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endfunction

    function automatic void check_str(input string name, input string got, input string want);
        int d;
        int g;
        int w;
        checks++;
        if (got != want) begin
            failures++;
            d = 0;
            while (d < got.len() && d < want.len() && got[d] == want[d]) d++;
            g = (d < got.len()) ? int'(got[d]) : -1;
            w = (d < want.len()) ? int'(want[d]) : -1;
            $display("FAIL %s: got len %0d want len %0d, first diff at %0d got byte %0d want byte %0d",
                     name, got.len(), want.len(), d, g, w);
        end
    endfunction

    // Reference text: each element printed in decimal, left-justified in a
    // field of DIGITS (+1 for signed) chars, then a space or LF at row end.
    function automatic string fmt(input int r, input int c, input bit sgn, input int v [25]);
        string s;
        string f;
        int fw;
        s = "";
        fw = sgn ? 4 : 3;
        for (int k = 0; k < r * c; k++) begin
            f = $sformatf("%0d", v[k]);
            while (f.len() < fw) f = {f, " "};
            if ((k % c) == c - 1) s = {s, f, "\n"};
            else s = {s, f, " "};
        end
        return s;
    endfunction

    // Compare process: transmitter model plus per-byte check against the model text.
    always @(negedge clk) begin
        m_st[0] = if_u.tx_start; m_td[0] = if_u.tx_data; m_bz[0] = if_u.tx_busy;
        m_dn[0] = done_u;        m_er[0] = err_u;
        m_st[1] = if_s.tx_start; m_td[1] = if_s.tx_data; m_bz[1] = if_s.tx_busy;
        m_dn[1] = done_s;        m_er[1] = err_s;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                busy_cd[i] = 0;
                prev_st[i] = 1'b0;
            end else begin
                if (m_st[i]) begin
                    check_int($sformatf("tx_start_handshake[%0d]", i), int'(m_bz[i] | prev_st[i]), 0);
                    m_es = exp_str[i];
                    if (pos[i] < m_es.len()) begin
                        check_int($sformatf("tx_byte[%0d].%0d", i, pos[i]), int'(m_td[i]), int'(m_es[pos[i]]));
                    end else begin
                        checks++;
                        failures++;
                        $display("FAIL tx_extra[%0d]: got byte %0d want no byte", i, m_td[i]);
                    end
                    pos[i]++;
                    tx_cnt[i]++;
                    rx[i] = $sformatf("%s%c", rx[i], m_td[i]);
                    busy_cd[i] = rand_lag[i] ? int'($urandom_range(1, 12)) : 10;
                end else if (busy_cd[i] > 0) begin
                    busy_cd[i]--;
                end
                prev_st[i] = m_st[i];
                if (m_dn[i]) done_cnt[i]++;
                if (m_er[i]) err_cnt[i]++;
            end
        end
        if_u.tx_busy = (busy_cd[0] > 0);
        if_s.tx_busy = (busy_cd[1] > 0);
    end

    task automatic drive_start(input int id, input logic v);
        if (id == 0) start_u = v;
        else start_s = v;
    endtask

    task automatic pack();
        int t;
        for (int k = 0; k < 25; k++) begin
            t = vals[k];
            data_flat[k*DW +: DW] = t[DW-1:0];
        end
    endtask

    task automatic clear_vals();
        for (int k = 0; k < 25; k++) vals[k] = 0;
    endtask

    task automatic rand_vals(input bit sgn);
        for (int k = 0; k < 25; k++) begin
            vals[k] = int'($urandom_range(0, 511));
            if (sgn) vals[k] = vals[k] - 256;
        end
    endtask

    task automatic prep(input int id, input int r, input int c, input bit want_err, input bit rnd);
        if (want_err) exp_str[id] = "";
        else exp_str[id] = fmt(r, c, id == 1, vals);
        pos[id] = 0; rx[id] = ""; tx_cnt[id] = 0;
        done_cnt[id] = 0; err_cnt[id] = 0; rand_lag[id] = rnd;
        rows_i = 3'(r); cols_i = 3'(c);
        pack();
    endtask

    task automatic run_job(input string tag, input int id, input int r, input int c,
                           input bit want_err, input int hold, input bit co_abort, input bit rnd);
        int t;
        prep(id, r, c, want_err, rnd);
        @(posedge clk); #2;
        drive_start(id, 1'b1);
        abort_i = co_abort;
        @(posedge clk); #2;
        abort_i = 1'b0;
        // Inputs change after acceptance; the snapshot must not follow them.
        rows_i = 3'd0; cols_i = 3'd7; data_flat = ~data_flat;
        t = 0;
        while ((done_cnt[id] + err_cnt[id]) == 0 && t < 20000) begin
            if (t >= hold) drive_start(id, 1'b0);
            @(posedge clk); #2;
            t++;
        end
        while (t < hold) begin
            @(posedge clk); #2;
            t++;
        end
        drive_start(id, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        check_int({tag, "_completed"}, int'((done_cnt[id] + err_cnt[id]) > 0), 1);
        check_int({tag, "_done_count"}, done_cnt[id], want_err ? 0 : 1);
        check_int({tag, "_err_count"}, err_cnt[id], want_err ? 1 : 0);
        check_int({tag, "_byte_count"}, tx_cnt[id], r * c * ((id == 1) ? 5 : 4) * (want_err ? 0 : 1));
        check_str({tag, "_text"}, rx[id], exp_str[id]);
        check_int({tag, "_busy_after"}, int'((id == 0) ? busy_u : busy_s), 0);
    endtask

    initial begin
        int t;
        int r;
        int c;
        string s;

        repeat (3) @(posedge clk);
        #2;
        check_int("rst_busy_u", int'(busy_u), 0);
        check_int("rst_done_u", int'(done_u), 0);
        check_int("rst_err_u", int'(err_u), 0);
        check_int("rst_tx_start_u", int'(if_u.tx_start), 0);
        check_int("rst_tx_data_u", int'(if_u.tx_data), 0);
        check_int("rst_busy_s", int'(busy_s), 0);
        check_int("rst_tx_start_s", int'(if_s.tx_start), 0);
        check_int("rst_tx_data_s", int'(if_s.tx_data), 0);
        rst = 1'b0;
        @(posedge clk); #2;

        // Pin the model itself with hand-written text.
        clear_vals();
        vals[0] = 0; vals[1] = 7; vals[2] = 42; vals[3] = 100; vals[4] = 511; vals[5] = 5;
        s = fmt(2, 3, 1'b0, vals);
        check_str("model_pin_unsigned", s, "0   7   42 \n100 511 5  \n");
        run_job("u2x3", 0, 2, 3, 1'b0, 0, 1'b0, 1'b0);
        check_str("u2x3_literal", rx[0], "0   7   42 \n100 511 5  \n");

        clear_vals();
        vals[0] = -256; vals[1] = 3;
        s = fmt(1, 2, 1'b1, vals);
        check_str("model_pin_signed", s, "-256 3   \n");
        run_job("s1x2", 1, 1, 2, 1'b0, 0, 1'b0, 1'b0);
        check_str("s1x2_literal", rx[1], "-256 3   \n");

        // Bad dimensions.
        run_job("err_rows0", 0, 0, 3, 1'b1, 0, 1'b0, 1'b0);
        run_job("err_cols6", 1, 2, 6, 1'b1, 0, 1'b0, 1'b0);

        // Start held high for 500 cycles: single print.
        clear_vals();
        vals[0] = 9;
        run_job("hold1x1", 0, 1, 1, 1'b0, 500, 1'b0, 1'b0);
        check_str("hold1x1_literal", rx[0], "9  \n");

        // Abort asserted in the same cycle as start in IDLE: start wins.
        rand_vals(1'b0);
        run_job("co_abort", 0, 2, 2, 1'b0, 0, 1'b1, 1'b1);

        // Abort while the third byte is on the wire.
        rand_vals(1'b0);
        prep(0, 5, 5, 1'b0, 1'b0);
        @(posedge clk); #2;
        start_u = 1'b1;
        @(posedge clk); #2;
        start_u = 1'b0;
        t = 0;
        while (tx_cnt[0] < 3 && t < 2000) begin
            @(posedge clk); #2;
            t++;
        end
        check_int("abort_reached_byte3", tx_cnt[0], 3);
        abort_i = 1'b1;
        @(posedge clk); #2;
        abort_i = 1'b0;
        repeat (200) @(posedge clk);
        #2;
        check_int("abort_byte_count", tx_cnt[0], 3);
        check_int("abort_done_count", done_cnt[0], 0);
        check_int("abort_busy", int'(busy_u), 0);
        m_es = exp_str[0];
        check_str("abort_text", rx[0], m_es.substr(0, 2));

        // Reset while the first element is converting.
        rand_vals(1'b0);
        prep(0, 2, 2, 1'b0, 1'b0);
        @(posedge clk); #2;
        start_u = 1'b1;
        @(posedge clk); #2;
        start_u = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_int("midrst_busy", int'(busy_u), 0);
        check_int("midrst_done", int'(done_u), 0);
        check_int("midrst_err", int'(err_u), 0);
        check_int("midrst_tx_start", int'(if_u.tx_start), 0);
        check_int("midrst_tx_data", int'(if_u.tx_data), 0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;
        check_int("midrst_bytes_before", tx_cnt[0], 0);
        run_job("after_rst", 0, 2, 2, 1'b0, 0, 1'b0, 1'b0);

        // Randomized matrices, dimensions and transmitter latency.
        for (int j = 0; j < 8; j++) begin
            r = int'($urandom_range(1, 5));
            c = int'($urandom_range(1, 5));
            rand_vals(j[0]);
            run_job($sformatf("rand%0d", j), j % 2, r, c, 1'b0, 0, 1'b0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
